// File: rtl/muldiv_defs.sv
// rtl/muldiv_defs.sv - shared func codes, FSM states and constants for muldiv_seq
package muldiv_defs;

  localparam int XLEN = 64;

  localparam logic [2:0] FUNC_MUL    = 3'b000;
  localparam logic [2:0] FUNC_MULH   = 3'b001;
  localparam logic [2:0] FUNC_MULHSU = 3'b010;
  localparam logic [2:0] FUNC_MULHU  = 3'b011;
  localparam logic [2:0] FUNC_DIV    = 3'b100;
  localparam logic [2:0] FUNC_DIVU   = 3'b101;
  localparam logic [2:0] FUNC_REM    = 3'b110;
  localparam logic [2:0] FUNC_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational radix-2 shift-add / restoring-divide iteration
module muldiv_step #(
  parameter int WIDTH = 64
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_opnd,
  input  logic             i_bit,
  output logic [WIDTH:0]   o_next,
  output logic             o_qbit
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;

  always_comb begin
    w_sum   = {1'b0, i_acc} + {1'b0, i_opnd & {WIDTH{i_bit}}};
    w_shift = {i_acc, i_bit};
    // Extra top bit of the trial subtraction is the borrow: set means divisor did not fit.
    w_diff  = {1'b0, w_shift} - {2'b00, i_opnd};
    o_qbit  = i_div & ~w_diff[WIDTH+1];
    if (!i_div) begin
      o_next = w_sum;
    end else if (o_qbit) begin
      o_next = w_diff[WIDTH:0];
    end else begin
      o_next = w_shift;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV64M multiply/divide/remainder sequencer
module muldiv_seq
  import muldiv_defs::*;
#(
  parameter int WIDTH = XLEN,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2:0]           r_func;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic                 r_neg;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_result;

  logic                 w_is_div;
  logic                 w_a_signed;
  logic                 w_b_signed;
  logic                 w_sa;
  logic                 w_sb;
  logic                 w_neg;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic                 w_b_zero;
  logic                 w_ovf;
  logic                 w_special;
  logic [WIDTH-1:0]     w_special_res;
  logic [WIDTH:0]       w_next;
  logic                 w_qbit;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_divsel;
  logic [WIDTH-1:0]     w_fix_res;

  always_comb begin
    w_is_div   = r_func[2];
    w_a_signed = w_is_div ? ~r_func[0] : (r_func[1:0] == 2'b01 || r_func[1:0] == 2'b10);
    w_b_signed = w_is_div ? ~r_func[0] : (r_func[1:0] == 2'b01);
    w_sa       = w_a_signed & r_a[WIDTH-1];
    w_sb       = w_b_signed & r_b[WIDTH-1];
    w_mag_a    = w_sa ? -r_a : r_a;
    w_mag_b    = w_sb ? -r_b : r_b;
    // Remainder follows the dividend; quotient and product follow the sign product.
    w_neg      = (w_is_div && r_func[1]) ? w_sa : (w_sa ^ w_sb);

    w_b_zero   = (r_b == '0);
    w_ovf      = (r_func == FUNC_DIV || r_func == FUNC_REM) &&
                 (r_a == INT_MIN) && (r_b == '1);
    w_special  = w_is_div & (w_b_zero | w_ovf);
    if (w_b_zero) begin
      w_special_res = r_func[1] ? r_a : '1;
    end else begin
      w_special_res = r_func[1] ? '0 : r_a;
    end

    w_prod     = r_neg ? -r_acc : r_acc;
    w_divsel   = r_func[1] ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];
    if (w_is_div) begin
      w_fix_res = r_neg ? -w_divsel : w_divsel;
    end else if (r_func[1:0] == 2'b00) begin
      w_fix_res = w_prod[WIDTH-1:0];
    end else begin
      w_fix_res = w_prod[2*WIDTH-1:WIDTH];
    end
  end

  // Multiply consumes multiplier LSBs from the low half; divide feeds dividend MSBs.
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div  (w_is_div),
    .i_acc  (r_acc[2*WIDTH-1:WIDTH]),
    .i_opnd (r_opnd),
    .i_bit  (w_is_div ? r_acc[WIDTH-1] : r_acc[0]),
    .o_next (w_next),
    .o_qbit (w_qbit)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start && !kill) w_state_nxt = ST_PREP;
      ST_PREP: begin
        if (kill)           w_state_nxt = ST_IDLE;
        else if (w_special) w_state_nxt = ST_DONE;
        else                w_state_nxt = ST_CALC;
      end
      ST_CALC: begin
        if (kill)               w_state_nxt = ST_IDLE;
        else if (r_cnt == '0)   w_state_nxt = ST_FIX;
      end
      ST_FIX:  w_state_nxt = kill ? ST_IDLE : ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_func   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !kill) begin
            r_func <= func;
            r_a    <= a;
            r_b    <= b;
          end
        end
        ST_PREP: begin
          if (!kill) begin
            r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
            r_opnd <= w_mag_b;
            r_neg  <= w_neg;
            r_cnt  <= CNT_W'(WIDTH - 1);
            if (w_special) r_result <= w_special_res;
          end
        end
        ST_CALC: begin
          if (!kill) begin
            r_acc <= w_is_div ? {w_next[WIDTH-1:0], r_acc[WIDTH-2:0], w_qbit}
                              : {w_next, r_acc[WIDTH-1:1]};
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_FIX: begin
          if (!kill) r_result <= w_fix_res;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != ST_IDLE);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq with arithmetic reference model
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [2:0]  func;
  logic [63:0] a;
  logic [63:0] b;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int          checks;
  int          failures;
  logic [63:0] last_res;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  muldiv_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .kill   (kill),
    .func   (func),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] f, input logic [63:0] x, input logic [63:0] y);
    logic signed [127:0] sp;
    logic [127:0]        up;
    longint              sx;
    longint              sy;
    sx = x;
    sy = y;
    case (f)
      3'd0: begin up = {64'd0, x} * {64'd0, y}; return up[63:0]; end
      3'd1: begin sp = $signed({{64{x[63]}}, x}) * $signed({{64{y[63]}}, y}); return sp[127:64]; end
      3'd2: begin sp = $signed({{64{x[63]}}, x}) * $signed({64'd0, y}); return sp[127:64]; end
      3'd3: begin up = {64'd0, x} * {64'd0, y}; return up[127:64]; end
      3'd4: begin
        if (y == 0) return ONES;
        if (x == MIN64 && y == ONES) return x;
        return sx / sy;
      end
      3'd5: return (y == 0) ? ONES : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == MIN64 && y == ONES) return 64'd0;
        return sx % sy;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [63:0] x, input logic [63:0] y);
    if (f[2] && (y == 0 || (!f[0] && x == MIN64 && y == ONES))) return 2;
    return 67;
  endfunction

  // Called at a negedge; returns at the negedge of c1.
  task automatic issue(input logic [2:0] f, input logic [63:0] x, input logic [63:0] y);
    func  = f;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = {$urandom, $urandom};
    b     = {$urandom, $urandom};
    func  = 3'($urandom_range(0, 7));
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [63:0] x, input logic [63:0] y);
    logic [63:0] exp;
    int          n;
    bit          busy_ok;
    exp     = model(f, x, y);
    busy_ok = 1'b1;
    issue(f, x, y);
    n = 1;
    while (!done && n < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check($sformatf("%s latency", tag), 64'(n), 64'(latency(f, x, y)));
    check($sformatf("%s busy", tag), {63'd0, busy_ok & busy}, 64'd1);
    check($sformatf("%s result", tag), result, exp);
    @(negedge clk);
    check($sformatf("%s done_pulse", tag), {62'd0, done, busy}, 64'd0);
    check($sformatf("%s hold", tag), result, exp);
    last_res = exp;
  endtask

  initial begin
    logic [63:0] x;
    logic [63:0] y;
    logic [2:0]  f;
    int          n;
    int          dones;
    int          done_at;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    kill     = 1'b0;
    func     = 3'd0;
    a        = '0;
    b        = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset result", result, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul 7*-3", 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    check("mul 7*-3 const", last_res, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("mulhu -1*-1", 3'd3, ONES, ONES);
    check("mulhu const", result, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulh -1*-1", 3'd1, ONES, ONES);
    check("mulh const", result, 64'd0);
    run_op("mulhsu -1*2", 3'd2, ONES, 64'd2);
    check("mulhsu const", result, ONES);
    run_op("div -7/2", 3'd4, -64'd7, 64'd2);
    check("div const", result, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("rem -7/2", 3'd6, -64'd7, 64'd2);
    check("rem const", result, ONES);
    run_op("divu 100/7", 3'd5, 64'd100, 64'd7);
    check("divu const", result, 64'd14);
    run_op("remu 100/7", 3'd7, 64'd100, 64'd7);
    check("remu const", result, 64'd2);
    run_op("divu 5/0", 3'd5, 64'd5, 64'd0);
    check("divu0 const", result, ONES);
    run_op("remu 5/0", 3'd7, 64'd5, 64'd0);
    check("remu0 const", result, 64'd5);
    run_op("div ovf", 3'd4, MIN64, ONES);
    check("div ovf const", result, MIN64);
    run_op("rem ovf", 3'd6, MIN64, ONES);
    check("rem ovf const", result, 64'd0);
    run_op("div 0 by 0", 3'd4, 64'd0, 64'd0);
    run_op("rem -5/0", 3'd6, -64'd5, 64'd0);
    run_op("mul min*-1", 3'd0, MIN64, ONES);
    run_op("mulh min*min", 3'd1, MIN64, MIN64);

    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(0, 7));
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: y = 64'd0;
        1: y = 64'($urandom_range(1, 9));
        2: x = MIN64;
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) x = 64'(int'($urandom)) ;
      run_op($sformatf("rand%0d f=%0d", i, f), f, x, y);
    end

    // start while busy must be ignored
    issue(3'd0, 64'd11, 64'd13);
    n = 1; dones = 0; done_at = 0;
    while (n < 80) begin
      if (n == 10) begin
        func = 3'd5; a = 64'd5; b = 64'd0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        done_at = n;
      end
      @(negedge clk);
      n++;
    end
    check("busy start dones", 64'(dones), 64'd1);
    check("busy start done_at", 64'(done_at), 64'd67);
    check("busy start result", result, 64'd143);
    last_res = 64'd143;

    // kill mid-CALC
    issue(3'd0, 64'd5, 64'd6);
    n = 1;
    while (n < 30) begin
      @(negedge clk);
      n++;
    end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill busy", {63'd0, busy}, 64'd0);
    dones = 0;
    repeat (70) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("kill no done", 64'(dones), 64'd0);
    check("kill result kept", result, last_res);

    // kill outranks start in IDLE
    func = 3'd0; a = 64'd2; b = 64'd2; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("kill vs start busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    check("kill vs start result", result, last_res);

    // asynchronous reset mid-CALC
    issue(3'd1, ONES, 64'd9);
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", {63'd0, busy}, 64'd0);
    check("async rst done", {63'd0, done}, 64'd0);
    check("async rst result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("mul 3*4 after reset", 3'd0, 64'd3, 64'd4);
    check("mul 3*4 const", result, 64'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative sequencer for RV64M multiply/divide/remainder, sitting beside the ALU in the execute stage. The control unit issues one operation with a start pulse. The block runs a radix-2 shift-add or restoring-divide loop over a fixed number of cycles, then presents a 64-bit result with a one-cycle done pulse. It owns all sign handling and the RISC-V divide-by-zero and overflow special cases.

## Interface
- `WIDTH`, 64, operand/result width; iteration count equals `WIDTH`.
- `CNT_W`, 6, iteration counter width, equal to clog2(`WIDTH`).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue request; sampled only in IDLE.
- `kill`  in  1  synchronous abort, e.g. pipeline flush.
- `func`  in  3  RV M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`, `b`  in  WIDTH  operands rs1/rs2; captured on accepted start.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  WIDTH  registered; holds the last value until the next `done`.

## Operation
- States:
  - IDLE: `start` & !`kill` → PREP. Latches `a`, `b`, `func`.
  - PREP: computes magnitudes and output sign, then loads the accumulator.
    - Multiply: `a` is treated as signed for MULH and MULHSU; `b` is signed for MULH only.
    - Divide/remainder: both operands are signed for DIV and REM.
    - Divide special case detected → DONE directly. Otherwise → CALC with counter = `WIDTH`-1.
  - CALC: one iteration per cycle. Counter reaches 0 → FIX.
  - FIX: applies sign correction, selects the result half or field, registers `result` → DONE.
  - DONE: `done`=1 → IDLE.
- Multiply: 2·WIDTH-bit product register. Each step adds the multiplicand if the multiplier LSB is 1, then shifts right. FIX negates the full 2·WIDTH product if the sign is set. MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- Divide: restoring divide on unsigned magnitudes, producing WIDTH-bit quotient and remainder. In FIX:
  - Quotient is negated if the operand signs differ (DIV only).
  - Remainder takes the sign of the dividend (REM only).
- Special cases, resolved in PREP:
  - `b`=0: DIV/DIVU → all ones; REM/REMU → `a`.
  - DIV with `a`=0x8000_0000_0000_0000 and `b`=all ones → `a`; REM with the same operands → 0.
  - Multiply has no special cases.
- `start` while `busy` is ignored and has no side effects.
- `kill` in any non-IDLE state → IDLE at the next edge. No `done`; `result` is unchanged. `kill` outranks `start` in IDLE.

## Timing
- Reset (`rst_n`=0, any state, asynchronous): state=IDLE, `busy`=0, `done`=0, `result`=0, counter=0. Takes effect immediately and aborts any operation in flight.
- Normal latency, with `start` sampled in cycle c0:
  - PREP in c1.
  - CALC in c2..c65 (64 cycles).
  - FIX in c66.
  - DONE in c67 with `done`=1.
  - IDLE in c68.
- Special-case latency: PREP in c1, DONE in c2 (`done` two cycles after `start`).
- `busy` rises in the cycle after `start` and falls in the cycle after `done`.
- Back-to-back issue: the earliest next `start` is sampled in the c68 IDLE cycle.
- `result` updates on the edge entering DONE and is stable from then until the next DONE.

## Structure
- Shared header `muldiv_defs`:
  - localparams for the eight `func` codes.
  - state encoding: IDLE, PREP, CALC, FIX, DONE, 3 bits.
  - constant INT_MIN = 1 followed by WIDTH-1 zeros.
- Sub-module `muldiv_step`: purely combinational single iteration. Inputs are mode, accumulator/remainder, multiplicand/divisor and the current bit. Outputs are the next accumulator/remainder and the quotient bit. The top level holds only the FSM, the counter and the registers.

## Test plan
- MUL `a`=7, `b`=-3 (0xFFFF…FFFD), `start` at c0 → `done` at c67 with `result`=0xFFFF_FFFF_FFFF_FFEB. `busy` is high c1..c67.
- MULHU `a`=`b`=0xFFFF…FFFF → `result`=0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands → 0. MULHSU `a`=-1, `b`=2 → 0xFFFF…FFFF.
- DIV -7/2 → 0xFFFF…FFFD (-3). REM -7/2 → 0xFFFF…FFFF (-1). DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → all ones; REMU 5/0 → 5. DIV 0x8000…0 / -1 → 0x8000…0; REM with the same operands → 0. All four give `done` at c2.
- `start` pulsed at c10 during a busy MUL → ignored; one `done` at c67 only. `kill` at c30 → IDLE at c31, no `done`, previous `result` retained.
- `rst_n` low at c40 mid-CALC, asynchronously → `busy`, `done` and `result` are 0 immediately. After release, a new MUL 3×4 → 12 at 67 cycles after its `start`.
